// File: rtl/sensor_group_packer_if.sv
// Frame-path bus of the sensor group packer: identifier results in,
// packed frames out through a valid/ready handshake, plus status.
// master = the packer, slave = the identifier/parser environment.
interface sensor_group_packer_if #(
   parameter int N_SENSORS = 3,
   parameter int ID_W      = 17,
   parameter int TS_W      = 24,
   parameter int DEPTH     = 4
);
   localparam int FRAME_W = N_SENSORS + TS_W + N_SENSORS*ID_W + ID_W;
   localparam int FILL_W  = $clog2(DEPTH) + 1;

   logic [TS_W-1:0]           sys_ts;
   logic [N_SENSORS*ID_W-1:0] pulse_ids;
   logic [ID_W-1:0]           polynomial;
   logic                      id_ready;
   logic                      reset_req;
   logic [FRAME_W-1:0]        out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic                      reset_identifier;
   logic [15:0]               drop_cnt;
   logic [FILL_W-1:0]         fill_level;

   modport master (
      input  sys_ts, pulse_ids, polynomial, id_ready, reset_req, out_ready,
      output out_data, out_valid, reset_identifier, drop_cnt, fill_level
   );

   modport slave (
      output sys_ts, pulse_ids, polynomial, id_ready, reset_req, out_ready,
      input  out_data, out_valid, reset_identifier, drop_cnt, fill_level
   );
endinterface

// File: rtl/sensor_group_packer.sv
// Packs per-sensor pulse ids with a validity mask and capture timestamp,
// queues frames in a first-word fall-through FIFO, counts overflow drops
// and pulses reset_identifier when results stop arriving.
module sensor_group_packer #(
   parameter int N_SENSORS = 3,
   parameter int ID_W      = 17,
   parameter int TS_W      = 24,
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 960000,
   parameter int RST_LEN   = 4
) (
   input  logic                  clk_96MHz,
   input  logic                  reset,
   sensor_group_packer_if.master bus
);
   localparam int FRAME_W = N_SENSORS + TS_W + N_SENSORS*ID_W + ID_W;
   localparam int AW      = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(TIMEOUT + 1);
   localparam int LEN_W   = $clog2(RST_LEN + 1);

   typedef enum logic {S_WAIT, S_FIRE} wd_state_t;

   logic                 id_ready_q;
   logic                 strobe, accept, pop, push, full, drop;
   logic [N_SENSORS-1:0] mask;
   logic [FRAME_W-1:0]   mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic [15:0]          drops;
   wd_state_t            state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [LEN_W-1:0]     len, len_n;

   // Only the rising edge of the level-type id_ready produces a frame;
   // strobes are ignored entirely while the identifier is being reset.
   assign strobe = bus.id_ready & ~id_ready_q;
   assign accept = strobe & (state == S_WAIT);
   assign full   = (count == (AW+1)'(DEPTH));
   assign pop    = (count != '0) & bus.out_ready;
   assign push   = accept & (~full | pop);
   assign drop   = accept & full & ~pop;

   // A sensor whose id is all-ones reported nothing usable.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N_SENSORS; i++)
         mask[i] = ~&bus.pulse_ids[i*ID_W +: ID_W];
   end

   // Edge-detect register for id_ready.
   always_ff @(posedge clk_96MHz or posedge reset) begin
      if (reset) id_ready_q <= 1'b0;
      else       id_ready_q <= bus.id_ready;
   end

   // Frame storage; contents only matter where count says they are valid.
   always_ff @(posedge clk_96MHz) begin
      if (push) mem[wr_ptr] <= {mask, bus.sys_ts, bus.pulse_ids, bus.polynomial};
   end

   // FIFO pointers and occupancy; power-of-2 depth makes pointers wrap.
   always_ff @(posedge clk_96MHz or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating count of frames lost to a full FIFO.
   always_ff @(posedge clk_96MHz or posedge reset) begin
      if (reset)                        drops <= '0;
      else if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
   end

   // Watchdog state register.
   always_ff @(posedge clk_96MHz or posedge reset) begin
      if (reset) begin
         state <= S_WAIT;
         cnt   <= '0;
         len   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         len   <= len_n;
      end
   end

   // Watchdog next state: timeout or request enters FIRE; FIRE lasts RST_LEN
   // cycles and comes back to WAIT with a fresh counter.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      len_n   = len;
      case (state)
         S_WAIT: begin
            if (cnt == CNT_W'(TIMEOUT - 1) || bus.reset_req) begin
               state_n = S_FIRE;
               cnt_n   = '0;
               len_n   = '0;
            end else if (strobe) begin
               cnt_n = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_FIRE: begin
            if (len == LEN_W'(RST_LEN - 1)) begin
               state_n = S_WAIT;
               len_n   = '0;
            end else begin
               len_n = len + LEN_W'(1);
            end
         end
         default: state_n = S_WAIT;
      endcase
   end

   // Head frame is forced to zero when empty so reset reads back all zeros.
   assign bus.out_valid        = (count != '0);
   assign bus.out_data         = (count != '0) ? mem[rd_ptr] : '0;
   assign bus.fill_level       = count;
   assign bus.drop_cnt         = drops;
   assign bus.reset_identifier = (state == S_FIRE);
endmodule

// File: tb/tb_sensor_group_packer.sv
// Bench for sensor_group_packer: directed scenarios plus a randomized run,
// compared against a queue-based frame model kept alongside the DUT.
module tb_sensor_group_packer;
   localparam int N       = 3;
   localparam int ID_W    = 17;
   localparam int TS_W    = 24;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 100;
   localparam int RST_LEN = 4;
   localparam int FW      = N + TS_W + N*ID_W + ID_W;
   localparam int FILL_W  = $clog2(DEPTH) + 1;
   localparam int VW      = 1 + FILL_W + 16 + 1 + FW;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [TS_W-1:0]   sys_ts = '0;
   logic [N*ID_W-1:0] pulse_ids = '0;
   logic [ID_W-1:0]   polynomial = '0;
   logic              id_ready = 1'b0;
   logic              reset_req = 1'b0;
   logic              out_ready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   sensor_group_packer_if #(.N_SENSORS(N), .ID_W(ID_W), .TS_W(TS_W), .DEPTH(DEPTH)) dif ();

   assign dif.sys_ts     = sys_ts;
   assign dif.pulse_ids  = pulse_ids;
   assign dif.polynomial = polynomial;
   assign dif.id_ready   = id_ready;
   assign dif.reset_req  = reset_req;
   assign dif.out_ready  = out_ready;

   sensor_group_packer #(
      .N_SENSORS(N), .ID_W(ID_W), .TS_W(TS_W), .DEPTH(DEPTH),
      .TIMEOUT(TIMEOUT), .RST_LEN(RST_LEN)
   ) dut (
      .clk_96MHz(clk),
      .reset(reset),
      .bus(dif.master)
   );

   always #5 clk = ~clk;

   logic [VW-1:0] dut_vec;
   assign dut_vec = {dif.out_valid, dif.fill_level, dif.drop_cnt, dif.reset_identifier, dif.out_data};

   // ---------------- reference model ----------------
   logic [FW-1:0] m_q[$];
   int            m_drop, m_idle, m_fire;
   bit            m_prev, m_stb;

   function automatic logic [FW-1:0] mk_frame(logic [N*ID_W-1:0] ids, logic [ID_W-1:0] poly,
                                              logic [TS_W-1:0] ts);
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) m[i] = (ids[i*ID_W +: ID_W] != {ID_W{1'b1}});
      return {m, ts, ids, poly};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [FW-1:0] d;
      d = (m_q.size() > 0) ? m_q[0] : '0;
      return {m_q.size() > 0, FILL_W'(m_q.size()), 16'(m_drop), m_fire > 0, d};
   endfunction

   // Model: pop the head if the consumer takes it, then a strobe outside a
   // reset pulse is stored if room remains, else counted as a drop.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_drop = 0; m_idle = 0; m_fire = 0; m_prev = 0;
      end else begin
         m_stb  = id_ready && !m_prev;
         m_prev = id_ready;
         if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
         if (m_stb && m_fire == 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(mk_frame(pulse_ids, polynomial, sys_ts));
            else if (m_drop < 16'hFFFF) m_drop++;
         end
         if (m_fire > 0) m_fire--;
         else if (m_idle == TIMEOUT-1 || reset_req) begin m_fire = RST_LEN; m_idle = 0; end
         else m_idle = m_stb ? 0 : m_idle + 1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic nxt();
      @(negedge clk);
      sys_ts = sys_ts + 1'b1;
   endtask

   task automatic do_reset();
      id_ready = 0; reset_req = 0; out_ready = 0;
      reset = 1;
      nxt(); nxt();
      reset = 0;
   endtask

   task automatic rand_ids();
      logic [N*ID_W-1:0] t;
      for (int i = 0; i < N; i++)
         t[i*ID_W +: ID_W] = ($urandom_range(0, 3) == 0) ? {ID_W{1'b1}} : ID_W'($urandom);
      pulse_ids  = t;
      polynomial = ID_W'($urandom);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      nxt(); id_ready = 1; nxt(); id_ready = 0; nxt();
      #2 reset = 1;
      #1;
      n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", dif.out_valid); end
      n_cmp++; if (dif.fill_level !== '0) begin n_bad++; $display("FAIL reset_fill got=%0d exp=0", dif.fill_level); end
      n_cmp++; if (dif.drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop got=%0d exp=0", dif.drop_cnt); end
      n_cmp++; if (dif.reset_identifier !== 1'b0) begin n_bad++; $display("FAIL reset_rid got=%b exp=0", dif.reset_identifier); end
      n_cmp++; if (dif.out_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", dif.out_data); end
      nxt();
      reset = 0;
   endtask

   task automatic test_single_frame();
      logic [N*ID_W-1:0] ids;
      logic [FW-1:0]     exp;
      int                extra;
      do_reset();
      nxt();
      ids = {17'h1FFFF, 17'h00123, 17'h00045};
      pulse_ids = ids; polynomial = 17'h0A5A5; sys_ts = 24'h000100;
      id_ready = 1; out_ready = 1;
      nxt();
      exp = {3'b011, 24'h000100, ids, 17'h0A5A5};
      n_cmp++; if (dif.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", dif.out_valid); end
      n_cmp++; if (dif.out_data !== exp) begin n_bad++; $display("FAIL single_data got=%h exp=%h", dif.out_data, exp); end
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) id_ready = 0;
         nxt();
         if (dif.out_valid) extra++;
      end
      n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL single_extra got=%0d exp=0", extra); end
      n_cmp++; if (dif.drop_cnt !== 16'd0) begin n_bad++; $display("FAIL single_drop got=%0d exp=0", dif.drop_cnt); end
   endtask

   task automatic test_overflow();
      logic [TS_W-1:0] ts_rec[6];
      do_reset();
      out_ready = 0;
      for (int s = 0; s < 6; s++) begin
         nxt(); rand_ids(); id_ready = 1; ts_rec[s] = sys_ts;
         nxt(); id_ready = 0;
      end
      nxt();
      n_cmp++; if (dif.fill_level !== FILL_W'(4)) begin n_bad++; $display("FAIL ovf_fill got=%0d exp=4", dif.fill_level); end
      n_cmp++; if (dif.drop_cnt !== 16'd2) begin n_bad++; $display("FAIL ovf_drop got=%0d exp=2", dif.drop_cnt); end
      out_ready = 1;
      for (int j = 0; j < 4; j++) begin
         n_cmp++;
         if (dif.out_valid !== 1'b1 || dif.out_data[FW-N-1 -: TS_W] !== ts_rec[j]) begin
            n_bad++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", j, dif.out_valid, dif.out_data[FW-N-1 -: TS_W], ts_rec[j]);
         end
         nxt();
      end
      n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got=%b exp=0", dif.out_valid); end
   endtask

   task automatic test_full_pop();
      logic [TS_W-1:0] ts_rec[5];
      do_reset();
      out_ready = 0;
      for (int s = 0; s < 4; s++) begin
         nxt(); rand_ids(); id_ready = 1; ts_rec[s] = sys_ts;
         nxt(); id_ready = 0;
      end
      nxt(); rand_ids(); id_ready = 1; out_ready = 1; ts_rec[4] = sys_ts;
      nxt(); id_ready = 0;
      n_cmp++; if (dif.fill_level !== FILL_W'(4)) begin n_bad++; $display("FAIL fullpop_fill got=%0d exp=4", dif.fill_level); end
      n_cmp++; if (dif.drop_cnt !== 16'd0) begin n_bad++; $display("FAIL fullpop_drop got=%0d exp=0", dif.drop_cnt); end
      for (int j = 1; j < 5; j++) begin
         n_cmp++;
         if (dif.out_valid !== 1'b1 || dif.out_data[FW-N-1 -: TS_W] !== ts_rec[j]) begin
            n_bad++; $display("FAIL fullpop_drain%0d got=%b/%h exp=1/%h", j, dif.out_valid, dif.out_data[FW-N-1 -: TS_W], ts_rec[j]);
         end
         nxt();
      end
   endtask

   task automatic test_watchdog();
      bit exp;
      do_reset();
      for (int k = 1; k <= 210; k++) begin
         nxt();
         exp = (k >= 100 && k <= 103) || (k >= 204 && k <= 207);
         n_cmp++; if (dif.reset_identifier !== exp) begin n_bad++; $display("FAIL wdog_k%0d got=%b exp=%b", k, dif.reset_identifier, exp); end
         n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL wdog_model_k%0d got=%h exp=%h", k, dut_vec, exp_vec()); end
      end
   endtask

   task automatic test_reset_req();
      bit exp;
      do_reset();
      out_ready = 0;
      for (int k = 1; k <= 20; k++) begin
         nxt();
         exp = (k >= 10 && k <= 13);
         n_cmp++; if (dif.reset_identifier !== exp) begin n_bad++; $display("FAIL rreq_k%0d got=%b exp=%b", k, dif.reset_identifier, exp); end
         n_cmp++;
         if (dif.out_valid !== 1'b0 || dif.drop_cnt !== 16'd0) begin
            n_bad++; $display("FAIL rreq_nofr_k%0d got=%b/%0d exp=0/0", k, dif.out_valid, dif.drop_cnt);
         end
         reset_req = (k == 9);
         if (k == 11) rand_ids();
         id_ready  = (k == 11);
      end
   endtask

   task automatic test_reset_mid();
      logic [TS_W-1:0] ts0;
      do_reset();
      out_ready = 0;
      for (int s = 0; s < 3; s++) begin
         nxt(); rand_ids(); id_ready = 1;
         nxt(); id_ready = 0;
      end
      nxt(); reset_req = 1;
      nxt(); reset_req = 0;
      nxt();
      n_cmp++;
      if (dif.fill_level !== FILL_W'(3) || dif.reset_identifier !== 1'b1) begin
         n_bad++; $display("FAIL mid_pre got=%0d/%b exp=3/1", dif.fill_level, dif.reset_identifier);
      end
      #2 reset = 1;
      #1;
      n_cmp++;
      if (dif.out_valid !== 1'b0 || dif.fill_level !== '0 || dif.reset_identifier !== 1'b0) begin
         n_bad++; $display("FAIL mid_clear got=%b/%0d/%b exp=0/0/0", dif.out_valid, dif.fill_level, dif.reset_identifier);
      end
      nxt(); reset = 0;
      nxt(); rand_ids(); id_ready = 1; ts0 = sys_ts;
      nxt(); id_ready = 0;
      n_cmp++;
      if (dif.out_valid !== 1'b1 || dif.fill_level !== FILL_W'(1) || dif.out_data[FW-N-1 -: TS_W] !== ts0) begin
         n_bad++; $display("FAIL mid_first got=%b/%0d/%h exp=1/1/%h", dif.out_valid, dif.fill_level, dif.out_data[FW-N-1 -: TS_W], ts0);
      end
      out_ready = 1;
      nxt();
      n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_sole got=%b exp=0", dif.out_valid); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 900; c++) begin
         nxt();
         n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rand_c%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
         rand_ids();
         id_ready  = ((c / 150) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
         reset_req = ($urandom_range(0, 79) == 0);
         out_ready = ((c / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_full_pop();
      test_watchdog();
      test_reset_req();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
